// File: rtl/reg_arb_pkg.sv
// Shared types and default widths for the register write arbiter.
// Imported by the arbiter top and its round-robin picker.
package reg_arb_pkg;

  localparam int DW = 16;
  localparam int AW = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  function automatic int ptr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Round-robin winner search over a request vector.
// Scans from ptr upward with wrap; purely combinational.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = ptr_bits(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    idx,
  output logic             valid
);

  logic [PW-1:0] cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PW'((int'(ptr) + k) % N_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter driving a shared clock-enabled register bank.
// Output registers hold the latched grant/address/data for the WRITE cycle.
module reg_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int N_REG = 8,
  parameter int DW    = reg_arb_pkg::DW,
  parameter int AW    = reg_arb_pkg::AW
) (
  input  logic                CLK,
  input  logic                CLR_N,
  input  logic [N_REQ-1:0]    REQ,
  input  logic [N_REQ*AW-1:0] ADDR,
  input  logic [N_REQ*DW-1:0] WDATA,
  output logic [N_REQ-1:0]    GNT,
  output logic [N_REG-1:0]    REG_CE,
  output logic [DW-1:0]       REG_D,
  output logic                BUSY,
  output logic                ERR
);

  import reg_arb_pkg::*;

  localparam int PW = ptr_bits(N_REQ);

  state_e        state, state_nx;
  logic [PW-1:0] ptr, ptr_nx;
  logic [PW-1:0] win;
  logic          win_valid;
  logic [AW-1:0] addr_w;
  logic [DW-1:0] data_w;

  logic [N_REQ-1:0] gnt_nx;
  logic [N_REG-1:0] ce_nx;
  logic [DW-1:0]    d_nx;
  logic             busy_nx;
  logic             err_nx;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req   (REQ),
    .ptr   (ptr),
    .idx   (win),
    .valid (win_valid)
  );

  always_comb begin
    addr_w = '0;
    data_w = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == PW'(i)) begin
        addr_w = ADDR[i*AW +: AW];
        data_w = WDATA[i*DW +: DW];
      end
    end
  end

  // Outputs are computed on the IDLE->WRITE edge, so they
  // double as the latched winner, address and data.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    gnt_nx   = '0;
    ce_nx    = '0;
    d_nx     = '0;
    busy_nx  = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (win_valid) begin
          state_nx = ST_WRITE;
          ptr_nx   = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
          busy_nx  = 1'b1;
          d_nx     = data_w;
          for (int i = 0; i < N_REQ; i++) begin
            gnt_nx[i] = (win == PW'(i));
          end
          if (int'(addr_w) < N_REG) begin
            for (int r = 0; r < N_REG; r++) begin
              ce_nx[r] = (int'(addr_w) == r);
            end
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      GNT    <= '0;
      REG_CE <= '0;
      REG_D  <= '0;
      BUSY   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      GNT    <= gnt_nx;
      REG_CE <= ce_nx;
      REG_D  <= d_nx;
      BUSY   <= busy_nx;
      ERR    <= err_nx;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed scoreboard bench for reg_write_arbiter.
// Main instance uses N_REG=8; a second uses N_REG=6 for the error path.
module tb_reg_write_arbiter;

  logic        CLK = 1'b0;
  logic        CLR_N;
  logic [3:0]  req, req6;
  logic [11:0] addr, addr6;
  logic [63:0] wdata, wdata6;

  logic [3:0]  gnt, gnt6;
  logic [7:0]  ce;
  logic [5:0]  ce6;
  logic [15:0] d, d6;
  logic        busy, busy6, err, err6;

  always #5 CLK = ~CLK;

  reg_write_arbiter #(
    .N_REQ(4), .N_REG(8), .DW(16), .AW(3)
  ) u_dut (
    .CLK(CLK), .CLR_N(CLR_N), .REQ(req), .ADDR(addr),
    .WDATA(wdata), .GNT(gnt), .REG_CE(ce), .REG_D(d),
    .BUSY(busy), .ERR(err)
  );

  reg_write_arbiter #(
    .N_REQ(4), .N_REG(6), .DW(16), .AW(3)
  ) u_dut6 (
    .CLK(CLK), .CLR_N(CLR_N), .REQ(req6), .ADDR(addr6),
    .WDATA(wdata6), .GNT(gnt6), .REG_CE(ce6), .REG_D(d6),
    .BUSY(busy6), .ERR(err6)
  );

  typedef struct packed {
    logic [3:0]  gnt;
    logic [7:0]  ce;
    logic [15:0] d;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] prev_gnt = 4'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] a,
                         input logic [15:0] v);
    req[i]           = 1'b1;
    addr[i*3 +: 3]   = a;
    wdata[i*16 +: 16] = v;
  endtask

  task automatic expect_gnt(input int i);
    exp_t e;
    logic [2:0] a;
    a     = addr[i*3 +: 3];
    e.gnt = 4'b1 << i;
    e.ce  = 8'b1 << a;
    e.d   = wdata[i*16 +: 16];
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge CLK);
    #1;
    if (gnt !== 4'b0) begin
      chk("gnt_gap", 64'(prev_gnt), 64'(4'b0));
      if (sb.size() == 0) begin
        chk("unexpected_gnt", 64'(gnt), 64'(4'b0));
      end else begin
        e = sb.pop_front();
        chk("gnt", 64'(gnt), 64'(e.gnt));
        chk("ce", 64'(ce), 64'(e.ce));
        chk("d", 64'(d), 64'(e.d));
        chk("busy", 64'(busy), 64'(1'b1));
        chk("err", 64'(err), 64'(1'b0));
      end
    end else begin
      chk("idle_ce", 64'(ce), 64'(8'b0));
      chk("idle_d", 64'(d), 64'(16'b0));
      chk("idle_busy", 64'(busy), 64'(1'b0));
    end
    prev_gnt = gnt;
  endtask

  initial begin
    CLR_N  = 1'b0;
    req    = '0;
    addr   = '0;
    wdata  = '0;
    req6   = '0;
    addr6  = '0;
    wdata6 = '0;
    #1;
    chk("rst_gnt", 64'(gnt), 64'(4'b0));
    chk("rst_ce", 64'(ce), 64'(8'b0));
    chk("rst_busy", 64'({busy, err, d}), 64'(18'b0));
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    CLR_N = 1'b1;

    // all four held: 0,1,2,3,0 on alternate cycles
    set_req(0, 3'd0, 16'h1000);
    set_req(1, 3'd1, 16'h1001);
    set_req(2, 3'd2, 16'h1002);
    set_req(3, 3'd7, 16'h1007);
    expect_gnt(0);
    expect_gnt(1);
    expect_gnt(2);
    expect_gnt(3);
    expect_gnt(0);
    for (int s = 0; s < 9; s++) step();
    req = '0;
    step();
    chk("t2_drained", 64'(sb.size()), 64'(0));

    // ptr=1, 3 and 0 requesting: 3 first, then 0
    set_req(0, 3'd1, 16'h3001);
    set_req(3, 3'd6, 16'h3006);
    expect_gnt(3);
    step();
    req[3] = 1'b0;
    expect_gnt(0);
    step();
    step();
    req = '0;
    step();
    chk("t3_drained", 64'(sb.size()), 64'(0));

    // single requester 2, fixed values
    set_req(2, 3'd5, 16'hBEEF);
    expect_gnt(2);
    step();
    chk("t1_gnt", 64'(gnt), 64'(4'b0100));
    chk("t1_ce", 64'(ce), 64'(8'b0010_0000));
    chk("t1_d", 64'(d), 64'(16'hBEEF));
    req = '0;
    step();
    chk("t1_after", 64'({gnt, ce, d, busy, err}), 64'(0));

    // ptr now 3: requester 3 beats 0 and 1
    set_req(0, 3'd3, 16'h4000);
    set_req(1, 3'd3, 16'h4001);
    set_req(3, 3'd4, 16'h4003);
    expect_gnt(3);
    step();
    req = '0;
    step();

    // requester 1 drops during requester 0's grant
    set_req(0, 3'd7, 16'hFFFF);
    set_req(1, 3'd4, 16'h6004);
    expect_gnt(0);
    step();
    req = '0;
    repeat (3) step();
    chk("t6_drained", 64'(sb.size()), 64'(0));

    // asynchronous reset mid-WRITE
    set_req(2, 3'd2, 16'h5A5A);
    expect_gnt(2);
    step();
    req = '0;
    #2;
    CLR_N = 1'b0;
    #1;
    chk("arst_gnt", 64'(gnt), 64'(4'b0));
    chk("arst_ce", 64'(ce), 64'(8'b0));
    chk("arst_d", 64'(d), 64'(16'b0));
    chk("arst_busy", 64'(busy), 64'(1'b0));
    @(posedge CLK);
    @(negedge CLK);
    CLR_N    = 1'b1;
    prev_gnt = 4'b0;
    set_req(1, 3'd1, 16'h7001);
    set_req(3, 3'd3, 16'h7003);
    expect_gnt(1);
    step();
    req[1] = 1'b0;
    expect_gnt(3);
    step();
    step();
    req = '0;
    step();

    // N_REG=6 instance: out-of-range addresses flag ERR
    req6           = 4'b0001;
    addr6[2:0]     = 3'd7;
    wdata6[15:0]   = 16'h1234;
    step();
    chk("e_gnt", 64'(gnt6), 64'(4'b0001));
    chk("e_err", 64'(err6), 64'(1'b1));
    chk("e_ce", 64'(ce6), 64'(6'b0));
    chk("e_d", 64'(d6), 64'(16'h1234));
    chk("e_busy", 64'(busy6), 64'(1'b1));
    req6 = '0;
    step();
    chk("e_after", 64'({gnt6, err6, busy6}), 64'(0));
    req6           = 4'b0011;
    addr6[2:0]     = 3'd5;
    wdata6[15:0]   = 16'h0505;
    addr6[5:3]     = 3'd6;
    wdata6[31:16]  = 16'h0606;
    step();
    chk("e6_gnt", 64'(gnt6), 64'(4'b0010));
    chk("e6_err", 64'(err6), 64'(1'b1));
    chk("e6_ce", 64'(ce6), 64'(6'b0));
    req6[1] = 1'b0;
    step();
    step();
    chk("e5_gnt", 64'(gnt6), 64'(4'b0001));
    chk("e5_ce", 64'(ce6), 64'(6'b10_0000));
    chk("e5_err", 64'(err6), 64'(1'b0));
    chk("e5_d", 64'(d6), 64'(16'h0505));
    req6 = '0;
    step();

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Shares one bank of N_REG DW-bit clock-enabled registers among N_REQ write requesters. Requesters present a request, address and data. The arbiter picks one requester by round-robin and drives the bank's per-register clock-enable and shared data bus for one cycle. It returns a one-cycle grant to the winner. It sits between requester logic and the register bank, and is the only source of the bank's CE and D inputs.

Parameters:
N_REQ, 4, number of write requesters (2..8)
N_REG, 8, number of registers in the bank (2..2**AW)
DW, 16, register data width
AW, 3, register address width

Ports:
CLK  input  1  rising-edge clock
CLR_N  input  1  asynchronous active-low reset
REQ  input  N_REQ  per-requester write request, level
ADDR  input  N_REQ*AW  per-requester target address; requester i uses bits [i*AW +: AW]
WDATA  input  N_REQ*DW  per-requester write data; requester i uses bits [i*DW +: DW]
GNT  output  N_REQ  one-hot one-cycle grant pulse
REG_CE  output  N_REG  one-hot per-register clock enable to the bank
REG_D  output  DW  shared write data to the bank
BUSY  output  1  high while in WRITE state
ERR  output  1  one-cycle pulse: granted address >= N_REG

Behaviour:
- Reset (CLR_N=0, asynchronous):
  - State=IDLE; round-robin pointer PTR=0.
  - GNT=0, REG_CE=0, REG_D=0, BUSY=0, ERR=0 immediately, independent of CLK.
  - Takes effect mid-write: the pending write is dropped, with no CE and no GNT.
- All outputs are registered. There is no combinational path from inputs to outputs.
- FSM has two states:
  - IDLE: if any REQ bit is high at a CLK edge, latch the winner index W, ADDR[W] and WDATA[W]. Go to WRITE. Otherwise stay in IDLE.
  - WRITE: lasts exactly one cycle, then returns to IDLE unconditionally. No arbitration happens in WRITE.
- Outputs during the WRITE cycle:
  - GNT[W]=1; BUSY=1; REG_D = latched data.
  - If latched address < N_REG: REG_CE[address]=1 and ERR=0.
  - Else: REG_CE all 0 and ERR=1.
  - All of these are 0 in IDLE. REG_D returns to 0 in IDLE.
- Latency: REQ sampled high at edge t gives GNT and REG_CE high in the cycle after t. The bank captures on edge t+1.
- Throughput: at most one write per 2 cycles.
- Round-robin:
  - Winner = first REQ bit set, searching PTR, PTR+1, ..., wrapping modulo N_REQ.
  - On entering WRITE, PTR = (W+1) mod N_REQ. Wrap from N_REQ-1 goes to 0.
  - PTR does not change in IDLE without a request.
- Handshake:
  - A requester holds REQ, ADDR and WDATA stable until it sees its GNT.
  - It may drop REQ in the cycle after GNT.
  - If REQ is still high in that following cycle, it competes again under round-robin. It is treated as a new request.
- A requester dropping REQ before being granted is legal. No grant is issued to it.
- Two requesters targeting the same address in consecutive grants: the later grant's data wins in the bank.
- Exactly zero or one bit of GNT and of REG_CE is high in any cycle.

Decomposition:
- Shared package reg_arb_pkg holds:
  - state encoding constants ST_IDLE=1'b0 and ST_WRITE=1'b1;
  - default widths DW=16 and AW=3.
- One sub-module, rr_pick:
  - combinational;
  - inputs: REQ vector and PTR;
  - outputs: winner index and any-valid flag.
- The FSM, PTR register and output registers stay in reg_write_arbiter.

Test Plan:
1. Reset then single requester: REQ=4'b0100, ADDR[2]=5, WDATA[2]=16'hBEEF.
   -> Next cycle: GNT=4'b0100, REG_CE=8'b0010_0000, REG_D=16'hBEEF, BUSY=1.
   -> Following cycle: all zero. PTR=3.
2. All four REQ held high continuously from reset.
   -> Grants in order 0,1,2,3,0 on every other cycle. GNT is never high in consecutive cycles.
3. Simultaneous REQ=4'b1001 with PTR=1.
   -> Requester 3 granted first. PTR=0. Requester 0 granted 2 cycles later. PTR=1.
4. N_REG=6 instance: ADDR=7, WDATA=16'h1234.
   -> GNT pulses, ERR=1, REG_CE=0 for that cycle. PTR still advances.
5. Assert CLR_N=0 asynchronously mid-WRITE cycle.
   -> GNT, REG_CE, REG_D and BUSY go 0 before the next CLK edge. After release: PTR=0, state IDLE. The next REQ=4'b0010 is granted normally.
6. Requester 1 drops REQ while requester 0 is being granted.
   -> Requester 1 receives no grant. Only GNT[0] pulses.
